// File: rtl/mem_pkg.sv
// Shared memory-side types: RAM port payloads and the write-buffer entry.
package mem_pkg;

    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DATA_W  = 32;
    localparam int WORD_OFFSET = 2;   // byte address bits below a word

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

    // One cycle of the single RAM port, shared with the mmu side.
    typedef struct packed {
        logic      we;
        mem_addr_t addr;
        mem_data_t w_data;
    } ram_req_t;

    // One posted store held in the write buffer.
    typedef struct packed {
        logic      valid;
        mem_addr_t addr;
        mem_data_t data;
    } wb_entry_t;

    localparam mem_addr_t WORD_MASK = ~mem_addr_t'((1 << WORD_OFFSET) - 1);

    // Two byte addresses name the same word when they differ only below WORD_OFFSET.
    function automatic logic same_word(input mem_addr_t a, input mem_addr_t b);
        return ((a ^ b) & WORD_MASK) == '0;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the write-buffer entries for read forwarding.
module wb_fwd_match
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t        entries [DEPTH],
    input  logic [PTR_W-1:0] tail,
    input  mem_addr_t        rd_addr,
    output logic             hit,
    output logic [PTR_W-1:0] index
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match wins.
    // NOTE: every always_comb output gets a default first, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PTR_W'(i);
            if (entries[idx].valid && same_word(entries[idx].addr, rd_addr)) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/ram_write_buffer.sv
// Posted write buffer between the mmu write-through path and the RAM port.
// Stores complete in one cycle, drain to RAM in FIFO order whenever no fill
// read owns the port, and fill reads see the youngest buffered copy of a word.
// DATA_WIDTH/ADDR_WIDTH must match the mem_pkg widths used by the entry type.
module ram_write_buffer
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_fwd,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_r_data,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    ptr_t      head;
    ptr_t      tail;
    cnt_t      count;

    logic      valid_q [DEPTH];
    mem_addr_t addr_q  [DEPTH];
    mem_data_t data_q  [DEPTH];
    wb_entry_t entries [DEPTH];

    logic      not_full;
    logic      do_enq;
    logic      do_drain;
    logic      fwd_hit;
    ptr_t      fwd_idx;
    ram_req_t  ram_req;

    // Handshake decode: enqueue needs a free slot, drain needs the port free of reads.
    always_comb begin
        not_full = (count < cnt_t'(DEPTH));
        do_enq   = rst && wr_valid && not_full;
        do_drain = rst && (count != '0) && !rd_valid;
    end

    // Pointers and occupancy; simultaneous enqueue and drain leave count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + ptr_t'(1);
            end
            if (do_drain) begin
                head <= head + ptr_t'(1);
            end
            case ({do_enq, do_drain})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry valid bits: set on enqueue at tail, cleared on drain at head.
    // Enqueue needs count<DEPTH and drain needs count>0, so tail==head never
    // sees both in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                valid_q[i] <= 1'b0;
            end else if (do_enq && (tail == ptr_t'(i))) begin
                valid_q[i] <= 1'b1;
            end else if (do_drain && (head == ptr_t'(i))) begin
                valid_q[i] <= 1'b0;
            end
        end
    end

    // Entry payload capture at tail.
    // NOTE: the address/data storage is deliberately not reset; valid_q alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_q[tail] <= wr_addr;
            data_q[tail] <= wr_data;
        end
    end

    // Pack the storage into entry records for the forwarding search.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid = valid_q[i];
            entries[i].addr  = addr_q[i];
            entries[i].data  = data_q[i];
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .entries (entries),
        .tail    (tail),
        .rd_addr (rd_addr),
        .hit     (fwd_hit),
        .index   (fwd_idx)
    );

    // RAM port mux: the head entry when draining, otherwise the read address.
    always_comb begin
        ram_req.we     = 1'b0;
        ram_req.addr   = rd_addr;
        ram_req.w_data = data_q[head];
        if (do_drain) begin
            ram_req.we   = 1'b1;
            ram_req.addr = addr_q[head];
        end
    end

    // Output decode; reset forces the idle, empty, non-forwarding view.
    always_comb begin
        ram_we     = ram_req.we;
        ram_addr   = ram_req.addr;
        ram_w_data = ram_req.w_data;
        wr_ready   = !rst || not_full;
        empty      = !rst || (count == '0);
        rd_fwd     = rst && fwd_hit;
        rd_data    = rd_fwd ? data_q[fwd_idx] : ram_r_data;
    end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed bench for ram_write_buffer with a write log of every RAM store.
module tb_ram_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_fwd;
    logic [31:0] ram_addr;
    logic [31:0] ram_w_data;
    logic        ram_we;
    logic [31:0] ram_r_data;
    logic        empty;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] wlog [$];

    localparam logic [31:0] RAM_WORD = 32'hCAFE_F00D;

    ram_write_buffer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_fwd     (rd_fwd),
        .ram_addr   (ram_addr),
        .ram_w_data (ram_w_data),
        .ram_we     (ram_we),
        .ram_r_data (ram_r_data),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Record every RAM write just before the edge that commits it.
    always @(negedge clk) begin
        if (ram_we) wlog.push_back({ram_addr, ram_w_data});
    end

    // The mmu never stores and reads the same word in one cycle.
    always @(negedge clk) begin
        if (rst === 1'b1)
            assert (!(wr_valid && rd_valid && (wr_addr[31:2] == rd_addr[31:2])))
                else $error("same-cycle store and read to one word");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare the write log against an expected list of {addr, data}.
    task automatic check_log(input string tag, input logic [63:0] exp [$]);
        logic [63:0] got;
        check({tag, "_n"}, 64'(wlog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < wlog.size()) ? wlog[i] : 64'hFFFF_FFFF_FFFF_FFFF;
            check($sformatf("%s_%0d", tag, i), got, exp[i]);
        end
        wlog.delete();
    endtask

    logic [63:0] exp_q [$];

    initial begin
        rst        = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_valid   = 1'b0;
        rd_addr    = 32'h800;
        ram_r_data = RAM_WORD;

        // 1 reset held for two cycles
        cyc();
        cyc();
        settle();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_rd_fwd", 64'(rd_fwd), 64'd0);
        check("rst_count", 64'(dut.count), 64'd0);
        rst = 1'b1;
        cyc();
        wlog.delete();

        // 2 single store, drains the next cycle
        wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hDEAD_BEEF;
        settle();
        check("s_ready", 64'(wr_ready), 64'd1);
        check("s_we_same_cycle", 64'(ram_we), 64'd0);
        cyc();
        wr_valid = 1'b0;
        settle();
        check("s_we", 64'(ram_we), 64'd1);
        check("s_addr", 64'(ram_addr), 64'h100);
        check("s_wdata", 64'(ram_w_data), 64'hDEAD_BEEF);
        check("s_empty_pending", 64'(empty), 64'd0);
        cyc();
        settle();
        check("s_empty_after", 64'(empty), 64'd1);
        check("s_we_after", 64'(ram_we), 64'd0);
        exp_q = '{{32'h100, 32'hDEAD_BEEF}};
        check_log("s_log", exp_q);

        // 3 fill with a read holding the port
        rd_valid = 1'b1; rd_addr = 32'h800;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = 32'h300 + 32'(4 * i); wr_data = 32'hA0 + 32'(i);
            settle();
            check($sformatf("f_ready_%0d", i), 64'(wr_ready), 64'd1);
            check($sformatf("f_we_%0d", i), 64'(ram_we), 64'd0);
            cyc();
        end
        wr_addr = 32'h3F0; wr_data = 32'hBAD;
        settle();
        check("f_full_ready", 64'(wr_ready), 64'd0);
        check("f_full_we", 64'(ram_we), 64'd0);
        check("f_full_raddr", 64'(ram_addr), 64'h800);
        check("f_full_count", 64'(dut.count), 64'd4);
        cyc();
        wr_valid = 1'b0; rd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("f_drain_we_%0d", i), 64'(ram_we), 64'd1);
            check($sformatf("f_drain_addr_%0d", i), 64'(ram_addr), 64'(32'h300 + 32'(4 * i)));
            cyc();
        end
        settle();
        check("f_empty", 64'(empty), 64'd1);
        exp_q = '{{32'h300, 32'hA0}, {32'h304, 32'hA1}, {32'h308, 32'hA2}, {32'h30C, 32'hA3}};
        check_log("f_log", exp_q);

        // 4 forwarding of the youngest match
        rd_valid = 1'b1; rd_addr = 32'h800;
        wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 32'h11;
        cyc();
        wr_data = 32'h22;
        cyc();
        wr_valid = 1'b0;
        rd_addr = 32'h200;
        settle();
        check("fw_data", 64'(rd_data), 64'h22);
        check("fw_hit", 64'(rd_fwd), 64'd1);
        check("fw_we", 64'(ram_we), 64'd0);
        rd_addr = 32'h204;
        settle();
        check("fw_miss_data", 64'(rd_data), 64'(RAM_WORD));
        check("fw_miss_hit", 64'(rd_fwd), 64'd0);
        check("fw_miss_raddr", 64'(ram_addr), 64'h204);
        cyc();
        rd_valid = 1'b0;
        cyc();
        cyc();
        settle();
        check("fw_empty", 64'(empty), 64'd1);
        exp_q = '{{32'h200, 32'h11}, {32'h200, 32'h22}};
        check_log("fw_log", exp_q);

        // 5 ten back-to-back stores with no reads
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_addr = 32'h400 + 32'(4 * i); wr_data = 32'h1000 + 32'(i);
            settle();
            check($sformatf("st_ready_%0d", i), 64'(wr_ready), 64'd1);
            check($sformatf("st_count_%0d", i), 64'(dut.count <= 1), 64'd1);
            cyc();
        end
        wr_valid = 1'b0;
        cyc();
        settle();
        check("st_empty", 64'(empty), 64'd1);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back({32'h400 + 32'(4 * i), 32'h1000 + 32'(i)});
        check_log("st_log", exp_q);

        // 6 reset with three pending stores
        rd_valid = 1'b1; rd_addr = 32'h800;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 32'h600 + 32'(4 * i); wr_data = 32'h60 + 32'(i);
            cyc();
        end
        wr_valid = 1'b0;
        settle();
        check("mr_pending", 64'(dut.count), 64'd3);
        rst = 1'b0;
        settle();
        check("mr_in_rst_empty", 64'(empty), 64'd1);
        check("mr_in_rst_we", 64'(ram_we), 64'd0);
        cyc();
        rst = 1'b1; rd_valid = 1'b0;
        settle();
        check("mr_empty", 64'(empty), 64'd1);
        check("mr_we", 64'(ram_we), 64'd0);
        cyc();
        cyc();
        check("mr_no_writes", 64'(wlog.size()), 64'd0);
        wr_valid = 1'b1; wr_addr = 32'h500; wr_data = 32'h55;
        cyc();
        wr_valid = 1'b0;
        cyc();
        settle();
        check("mr_empty_after", 64'(empty), 64'd1);
        exp_q = '{{32'h500, 32'h55}};
        check_log("mr_log", exp_q);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
